// File: rtl/sess_flag_ctrl.sv
// Session flag controller: holds the inventory session flags, services
// NVM read/write handshakes and decays sessions S1 and up on a tick timebase.
module sess_flag_ctrl #(
    parameter int NSESS      = 4,
    parameter int AW         = 2,
    parameter int PW         = 12,
    parameter int S1_PERSIST = 500,
    parameter int SX_PERSIST = 2000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_srd_pulse,
    input  logic             par_srd_pulse,
    input  logic             swr_pulse,
    input  logic [AW-1:0]    saddr,
    input  logic             swr_data,
    input  logic [NSESS-1:0] sdin,
    input  logic             sack,
    input  logic             tick,
    output logic             SRD,
    output logic             SWR,
    output logic [NSESS-1:0] S_FLAGS,
    output logic [NSESS-1:0] UPD,
    output logic             BUSY
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    localparam logic [AW:0]   NS_LIM = (AW+1)'(NSESS);
    localparam logic [PW-1:0] LD_S1  = PW'(S1_PERSIST);
    localparam logic [PW-1:0] LD_SX  = PW'(SX_PERSIST);

    state_t           state, state_nx;
    logic             srd_nx, swr_nx, busy_nx;
    logic [NSESS-1:0] flags_nx, upd_nx;
    logic [PW-1:0]    cnt    [1:NSESS-1];
    logic [PW-1:0]    cnt_nx [1:NSESS-1];

    logic             pend_v, pend_v_nx;
    logic [AW-1:0]    pend_a, pend_a_nx;
    logic             pend_d, pend_d_nx;

    logic             rd_req, wr_ok, latch_wr, do_rd, do_wr;
    logic [AW-1:0]    wr_a;
    logic             wr_d;

    assign rd_req = init_srd_pulse | par_srd_pulse;
    assign wr_ok  = swr_pulse && ({1'b0, saddr} < NS_LIM);

    // Transaction sequencing: choose next state, handshake levels and pending-slot update
    always_comb begin
        state_nx  = state;
        srd_nx    = SRD;
        swr_nx    = SWR;
        do_rd     = 1'b0;
        do_wr     = 1'b0;
        latch_wr  = 1'b0;
        wr_a      = saddr;
        wr_d      = swr_data;
        pend_v_nx = pend_v;
        pend_a_nx = pend_a;
        pend_d_nx = pend_d;
        unique case (state)
            IDLE: begin
                // A queued write goes first; anything arriving alongside it is queued or dropped
                if (pend_v) begin
                    do_wr     = 1'b1;
                    wr_a      = pend_a;
                    wr_d      = pend_d;
                    pend_v_nx = 1'b0;
                    latch_wr  = wr_ok;
                end else if (rd_req) begin
                    state_nx = RD;
                    srd_nx   = 1'b1;
                    latch_wr = wr_ok;
                end else if (wr_ok) begin
                    do_wr = 1'b1;
                end
            end
            RD: begin
                latch_wr = wr_ok;
                if (sack) begin
                    do_rd    = 1'b1;
                    srd_nx   = 1'b0;
                    state_nx = IDLE;
                end
            end
            WR: begin
                latch_wr = wr_ok;
                if (sack) begin
                    swr_nx   = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (do_wr) begin
            state_nx = WR;
            swr_nx   = 1'b1;
        end
        if (latch_wr) begin
            pend_v_nx = 1'b1;
            pend_a_nx = saddr;
            pend_d_nx = swr_data;
        end
        busy_nx = (state_nx != IDLE);
    end

    // Flag and persistence update: decay first, then a read load or write overrides it
    always_comb begin
        flags_nx = S_FLAGS;
        upd_nx   = '0;
        cnt_nx   = cnt;
        for (int unsigned k = 1; k < NSESS; k++) begin
            if (tick && cnt[k] != '0) begin
                cnt_nx[k] = cnt[k] - PW'(1);
                if (cnt[k] == PW'(1)) begin
                    flags_nx[k] = 1'b0;
                    upd_nx[k]   = 1'b1;
                end
            end
        end
        if (do_rd) begin
            flags_nx = sdin;
            upd_nx   = '0;
            for (int unsigned k = 1; k < NSESS; k++)
                cnt_nx[k] = sdin[k] ? ((k == 1) ? LD_S1 : LD_SX) : '0;
        end
        if (do_wr) begin
            for (int unsigned k = 0; k < NSESS; k++) begin
                if (wr_a == AW'(k)) begin
                    flags_nx[k] = wr_d;
                    upd_nx[k]   = 1'b1;
                end
            end
            for (int unsigned k = 1; k < NSESS; k++) begin
                if (wr_a == AW'(k))
                    cnt_nx[k] = wr_d ? ((k == 1) ? LD_S1 : LD_SX) : '0;
            end
        end
    end

    // FSM state and handshake output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            SRD   <= 1'b0;
            SWR   <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nx;
            SRD   <= srd_nx;
            SWR   <= swr_nx;
            BUSY  <= busy_nx;
        end
    end

    // Flag, strobe, persistence counter and pending-slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_FLAGS <= '0;
            UPD     <= '0;
            pend_v  <= 1'b0;
            pend_a  <= '0;
            pend_d  <= 1'b0;
            for (int unsigned k = 1; k < NSESS; k++)
                cnt[k] <= '0;
        end else begin
            S_FLAGS <= flags_nx;
            UPD     <= upd_nx;
            pend_v  <= pend_v_nx;
            pend_a  <= pend_a_nx;
            pend_d  <= pend_d_nx;
            cnt     <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_sess_flag_ctrl.sv
// Bench for sess_flag_ctrl: reference model plus directed scenarios.
module tb_sess_flag_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         init_srd_pulse = 1'b0;
    logic         par_srd_pulse = 1'b0;
    logic         swr_pulse = 1'b0;
    logic [1:0]   saddr = '0;
    logic         swr_data = 1'b0;
    logic [N-1:0] sdin = '0;
    logic         sack = 1'b0;
    logic         tick = 1'b0;

    logic         SRD, SWR, BUSY;
    logic [N-1:0] S_FLAGS, UPD;
    logic         SRD3, SWR3, BUSY3;
    logic [2:0]   S_FLAGS3, UPD3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sess_flag_ctrl #(.NSESS(4), .AW(2), .PW(12), .S1_PERSIST(500), .SX_PERSIST(2000)) u_dut (
        .clk(clk), .rst_n(rst_n), .init_srd_pulse(init_srd_pulse), .par_srd_pulse(par_srd_pulse),
        .swr_pulse(swr_pulse), .saddr(saddr), .swr_data(swr_data), .sdin(sdin), .sack(sack),
        .tick(tick), .SRD(SRD), .SWR(SWR), .S_FLAGS(S_FLAGS), .UPD(UPD), .BUSY(BUSY)
    );

    sess_flag_ctrl #(.NSESS(3), .AW(2), .PW(12), .S1_PERSIST(500), .SX_PERSIST(2000)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .init_srd_pulse(init_srd_pulse), .par_srd_pulse(par_srd_pulse),
        .swr_pulse(swr_pulse), .saddr(saddr), .swr_data(swr_data), .sdin(sdin[2:0]), .sack(sack),
        .tick(tick), .SRD(SRD3), .SWR(SWR3), .S_FLAGS(S_FLAGS3), .UPD(UPD3), .BUSY(BUSY3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: transaction flags, remaining persistence ticks, queued write
    logic [N-1:0] m_flags, m_upd;
    bit           m_rd, m_wr;
    int           rem [N];
    int           pq [$];

    function automatic int persist(input int k);
        return (k == 1) ? 500 : 2000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flags = '0;
            m_upd   = '0;
            m_rd    = 0;
            m_wr    = 0;
            pq.delete();
            for (int k = 0; k < N; k++) rem[k] = 0;
        end else begin
            bit go;
            bit ok;
            bit wd;
            int wa;
            go = 0; wa = 0; wd = 0;
            ok = swr_pulse && (int'(saddr) < N);
            m_upd = '0;
            for (int k = 1; k < N; k++) begin
                if (tick && rem[k] > 0) begin
                    rem[k] = rem[k] - 1;
                    if (rem[k] == 0) begin
                        m_flags[k] = 1'b0;
                        m_upd[k]   = 1'b1;
                    end
                end
            end
            if (!m_rd && !m_wr) begin
                if (pq.size() > 0) begin
                    go = 1;
                    wa = pq[0] / 2;
                    wd = (pq[0] % 2) != 0;
                    pq.delete();
                    if (ok) pq.push_back(int'(saddr) * 2 + int'(swr_data));
                end else if (init_srd_pulse || par_srd_pulse) begin
                    m_rd = 1;
                    if (ok) pq.push_back(int'(saddr) * 2 + int'(swr_data));
                end else if (ok) begin
                    go = 1;
                    wa = int'(saddr);
                    wd = swr_data;
                end
            end else begin
                if (ok) begin
                    pq.delete();
                    pq.push_back(int'(saddr) * 2 + int'(swr_data));
                end
                if (sack) begin
                    if (m_rd) begin
                        m_rd    = 0;
                        m_flags = sdin;
                        m_upd   = '0;
                        for (int k = 1; k < N; k++) rem[k] = sdin[k] ? persist(k) : 0;
                    end else begin
                        m_wr = 0;
                    end
                end
            end
            if (go) begin
                m_wr = 1;
                m_flags[wa] = wd;
                m_upd[wa]   = 1'b1;
                if (wa >= 1) rem[wa] = wd ? persist(wa) : 0;
            end
        end
    end

    // Every-cycle comparison of the main instance against the model
    always @(negedge clk) begin
        chk("SRD", SRD, m_rd);
        chk("SWR", SWR, m_wr);
        chk("BUSY", BUSY, m_rd | m_wr);
        chk("S_FLAGS", S_FLAGS, m_flags);
        chk("UPD", UPD, m_upd);
    end

    task automatic write_req(input logic [1:0] a, input logic d);
        swr_pulse = 1'b1; saddr = a; swr_data = d;
        @(negedge clk);
        swr_pulse = 1'b0;
    endtask

    task automatic ack1();
        sack = 1'b1;
        @(negedge clk);
        sack = 1'b0;
    endtask

    initial begin
        int hi;
        #1;
        chk("rst_srd", SRD, 0);
        chk("rst_swr", SWR, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_flags", S_FLAGS, 0);
        chk("rst_upd", UPD, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_srd", SRD, 0);
        chk("post_rst_swr", SWR, 0);

        // Out-of-range address on the 3-session instance; S3 is valid on the 4-session one
        write_req(2'd3, 1'b1);
        chk("bad_addr_swr3", SWR3, 0);
        chk("bad_addr_busy3", BUSY3, 0);
        chk("bad_addr_upd3", UPD3, 0);
        chk("bad_addr_flags3", S_FLAGS3, 0);
        chk("s3_write_upd", UPD, 4'b1000);
        ack1();
        chk("bad_addr_flags3_later", S_FLAGS3, 0);
        chk("bad_addr_srd3", SRD3, 0);

        // Read: SRD high three cycles, flags load with no strobe
        sdin = 4'b1010;
        init_srd_pulse = 1'b1;
        @(negedge clk);
        init_srd_pulse = 1'b0;
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            if (SRD) hi++;
            if (i == 2) sack = 1'b1;
            @(negedge clk);
        end
        sack = 1'b0;
        chk("rd_srd_cycles", hi, 3);
        chk("rd_srd_drop", SRD, 0);
        chk("rd_flags", S_FLAGS, 4'b1010);
        chk("rd_upd", UPD, 0);

        // Read-loaded persistence: S1 expires on tick 500, S3 on tick 2000
        tick = 1'b1;
        repeat (499) @(negedge clk);
        chk("rd_s1_hold", S_FLAGS, 4'b1010);
        @(negedge clk);
        chk("rd_s1_expire", S_FLAGS, 4'b1000);
        chk("rd_s1_expire_upd", UPD, 4'b0010);
        repeat (1499) @(negedge clk);
        chk("rd_s3_hold", S_FLAGS, 4'b1000);
        @(negedge clk);
        chk("rd_s3_expire", S_FLAGS, 4'b0000);
        chk("rd_s3_expire_upd", UPD, 4'b1000);
        tick = 1'b0;

        // Write S1=B: strobe one cycle after the pulse, SWR high two cycles
        write_req(2'd1, 1'b1);
        chk("wr_flags", S_FLAGS, 4'b0010);
        chk("wr_upd", UPD, 4'b0010);
        hi = 0;
        for (int i = 0; i < 2; i++) begin
            if (SWR) hi++;
            if (i == 1) sack = 1'b1;
            @(negedge clk);
        end
        sack = 1'b0;
        chk("wr_swr_cycles", hi, 2);
        chk("wr_swr_drop", SWR, 0);

        // Written S1 decays on the 500th tick
        tick = 1'b1;
        repeat (499) @(negedge clk);
        chk("wr_s1_hold", S_FLAGS, 4'b0010);
        @(negedge clk);
        chk("wr_s1_expire", S_FLAGS, 4'b0000);
        chk("wr_s1_expire_upd", UPD, 4'b0010);
        tick = 1'b0;

        // S0 never decays
        write_req(2'd0, 1'b1);
        ack1();
        tick = 1'b1;
        repeat (5000) @(negedge clk);
        tick = 1'b0;
        chk("s0_persist", S_FLAGS, 4'b0001);

        // Write to S2 in the same cycle S1 expires: both take effect
        write_req(2'd1, 1'b1);
        ack1();
        tick = 1'b1;
        repeat (499) @(negedge clk);
        write_req(2'd2, 1'b1);
        tick = 1'b0;
        chk("diff_sess_flags", S_FLAGS, 4'b0101);
        chk("diff_sess_upd", UPD, 4'b0110);
        ack1();

        // Write to S1 in the same cycle S1 expires: write wins and reloads
        write_req(2'd1, 1'b1);
        ack1();
        tick = 1'b1;
        repeat (499) @(negedge clk);
        write_req(2'd1, 1'b1);
        tick = 1'b0;
        chk("same_sess_flags", S_FLAGS, 4'b0111);
        chk("same_sess_upd", UPD, 4'b0010);
        ack1();
        tick = 1'b1;
        repeat (499) @(negedge clk);
        chk("reload_hold", S_FLAGS[1], 1);
        @(negedge clk);
        chk("reload_expire", S_FLAGS[1], 0);
        tick = 1'b0;

        // Read and write together: read first, then the queued write
        sdin = 4'b0001;
        par_srd_pulse = 1'b1;
        write_req(2'd2, 1'b1);
        par_srd_pulse = 1'b0;
        chk("coll_srd", SRD, 1);
        chk("coll_swr", SWR, 0);
        @(negedge clk);
        ack1();
        chk("coll_rd_done_busy", BUSY, 0);
        chk("coll_rd_flags", S_FLAGS, 4'b0001);
        @(negedge clk);
        chk("coll_wr_swr", SWR, 1);
        chk("coll_wr_upd", UPD, 4'b0100);
        chk("coll_wr_flags", S_FLAGS, 4'b0101);
        ack1();

        // A second write during the read replaces the queued one
        sdin = 4'b0011;
        par_srd_pulse = 1'b1;
        write_req(2'd2, 1'b1);
        par_srd_pulse = 1'b0;
        write_req(2'd3, 1'b1);
        ack1();
        chk("ovr_rd_flags", S_FLAGS, 4'b0011);
        @(negedge clk);
        chk("ovr_wr_upd", UPD, 4'b1000);
        chk("ovr_wr_flags", S_FLAGS, 4'b1011);
        ack1();

        // Reset in the middle of a write clears everything immediately
        write_req(2'd1, 1'b0);
        chk("mid_wr_swr", SWR, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_swr", SWR, 0);
        chk("rst_mid_srd", SRD, 0);
        chk("rst_mid_busy", BUSY, 0);
        chk("rst_mid_flags", S_FLAGS, 0);
        chk("rst_mid_upd", UPD, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst2_busy", BUSY, 0);
        chk("post_rst2_swr", SWR, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
